// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the NxN output-stationary systolic multiplier.
package systolic_pkg;

    localparam int DEF_N  = 3;
    localparam int DEF_DW = 8;
    localparam int DEF_OW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Wide enough for N full-scale products without overflow.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/sa_mac_cell.sv
// One processing element: registered A/B pass-through plus a clearable, enabled accumulator.
module sa_mac_cell
    import systolic_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = acc_width(DEF_DW, DEF_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [AW-1:0] acc_o
);

    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [2*DW-1:0] prod;

    always_comb begin
        prod  = (2*DW)'(a_i) * (2*DW)'(b_i);
        a_d   = a_i;
        b_d   = b_i;
        acc_d = acc_q;
        if (clr_i) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary systolic matrix multiplier with internal operand skew.
// Define SYSTOLIC_ARRAY_SAT_EN to saturate result elements instead of wrapping.
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int OW = DEF_OW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [N*N*DW-1:0] a_i,
    input  logic [N*N*DW-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N*N*OW-1:0] c_o
);

    localparam int AW = acc_width(DW, N);
    localparam int XW = AW + OW;
    localparam int TW = $clog2(3 * N);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [N*N*DW-1:0] a_op_q, a_op_d, b_op_q, b_op_d;
    logic [N*N*OW-1:0] c_q, c_d, c_res;
    logic              clr, en;

    logic [DW-1:0] a_feed  [N];
    logic [DW-1:0] b_feed  [N];
    logic [DW-1:0] a_east  [N][N];
    logic [DW-1:0] b_south [N][N];
    logic [AW-1:0] acc     [N][N];
    logic [XW-1:0] ext;
    logic          unused_sink;
    int            idx;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_op_d  = a_op_q;
        b_op_d  = b_op_q;
        c_d     = c_q;
        clr     = 1'b0;
        en      = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_FEED: begin
                busy_o = 1'b1;
                en     = 1'b1;
                if (t_q == T_LAST) state_d = S_DRAIN;
                else               t_d     = t_q + 1'b1;
            end
            S_DRAIN: begin
                busy_o  = 1'b1;
                c_d     = c_res;
                state_d = S_DONE;
            end
            default: begin
                done_o = (state_q == S_DONE);
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_FEED;
                    t_d     = '0;
                    a_op_d  = a_i;
                    b_op_d  = b_i;
                    clr     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_op_q  <= '0;
            b_op_q  <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_op_q  <= a_op_d;
            b_op_q  <= b_op_d;
            c_q     <= c_d;
        end
    end

    // Row r sees A(r, t-r) and column c sees B(t-c, c); zero outside the matrix.
    always_comb begin
        idx = 0;
        for (int r = 0; r < N; r++) begin
            a_feed[r] = '0;
            b_feed[r] = '0;
            if (state_q == S_FEED) begin
                idx = int'(t_q) - r;
                if (idx >= 0 && idx < N) begin
                    a_feed[r] = a_op_q[(r*N + idx)*DW +: DW];
                    b_feed[r] = b_op_q[(idx*N + r)*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        c_res       = '0;
        ext         = '0;
        unused_sink = 1'b0;
        for (int r = 0; r < N; r++) begin
            unused_sink = unused_sink ^ (^a_east[r][N-1]) ^ (^b_south[N-1][r]);
            for (int c = 0; c < N; c++) begin
                ext = XW'(acc[r][c]);
`ifdef SYSTOLIC_ARRAY_SAT_EN
                if (|ext[XW-1:OW]) c_res[(r*N + c)*OW +: OW] = {OW{1'b1}};
                else               c_res[(r*N + c)*OW +: OW] = ext[OW-1:0];
`else
                c_res[(r*N + c)*OW +: OW] = ext[OW-1:0];
                unused_sink = unused_sink ^ (^ext[XW-1:OW]);
`endif
            end
        end
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            logic [DW-1:0] a_in, b_in;
            if (gc == 0) begin : g_aw
                assign a_in = a_feed[gr];
            end else begin : g_ai
                assign a_in = a_east[gr][gc-1];
            end
            if (gr == 0) begin : g_bn
                assign b_in = b_feed[gc];
            end else begin : g_bi
                assign b_in = b_south[gr-1][gc];
            end
            sa_mac_cell #(.DW(DW), .AW(AW)) u_cell (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr),
                .en_i  (en),
                .a_i   (a_in),
                .b_i   (b_in),
                .a_o   (a_east[gr][gc]),
                .b_o   (b_south[gr][gc]),
                .acc_o (acc[gr][gc])
            );
        end
    end

    assign c_o = c_q;

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed scoreboard bench for systolic_array_nxn at N=3 and N=4.
module tb_systolic_array_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start3, start4;
    logic [71:0]  a3, b3;
    logic [127:0] a4, b4;
    logic         busy3, done3, busy4, done4;
    logic [143:0] c3;
    logic [255:0] c4;

    systolic_array_nxn #(.N(3), .DW(8), .OW(16)) dut3 (
        .clk(clk), .rst(rst), .start_i(start3), .a_i(a3), .b_i(b3),
        .busy_o(busy3), .done_o(done3), .c_o(c3)
    );

    systolic_array_nxn #(.N(4), .DW(8), .OW(16)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .c_o(c4)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, done3_cnt = 0, d0;
    logic [255:0] exp3_q[$], exp4_q[$];
    logic [255:0] last3, ev;
    logic [127:0] pa, pb;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done3) done3_cnt <= done3_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] ref_mul(input int n, input logic [127:0] a, input logic [127:0] b);
        logic [255:0] res = '0;
        longint s;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(a[(r*n + k)*8 +: 8]) * longint'(b[(k*n + c)*8 +: 8]);
`ifdef SYSTOLIC_ARRAY_SAT_EN
                res[(r*n + c)*16 +: 16] = (s > 65535) ? 16'hFFFF : 16'(s);
`else
                res[(r*n + c)*16 +: 16] = 16'(s);
`endif
            end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_start(input int which, input logic [127:0] a, input logic [127:0] b);
        if (which == 3) begin a3 = a[71:0]; b3 = b[71:0]; start3 = 1'b1; end
        else            begin a4 = a;       b4 = b;       start4 = 1'b1; end
        @(posedge clk);
        #1;
        start3 = 1'b0;
        start4 = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int which, input string tag, input int exp_lat);
        logic seen = 1'b0;
        logic [255:0] e;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = (which == 3) ? done3 : done4;
        end
        chk({tag, "_latency"}, 256'(cyc - start_cyc + 1), 256'(exp_lat));
        if (which == 3) begin
            chk({tag, "_sb_depth"}, 256'(exp3_q.size()), 256'd1);
            chk({tag, "_busy_in_done"}, 256'(busy3), 256'd0);
            if (exp3_q.size() > 0) begin
                e = exp3_q.pop_front();
                last3 = e;
                chk({tag, "_c"}, 256'(c3), e);
            end
        end else begin
            chk({tag, "_sb_depth"}, 256'(exp4_q.size()), 256'd1);
            if (exp4_q.size() > 0) begin
                e = exp4_q.pop_front();
                chk({tag, "_c"}, c4, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
        a3 = '0; b3 = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy3", 256'(busy3), 256'd0);
        chk("rst_done3", 256'(done3), 256'd0);
        chk("rst_c3", 256'(c3), 256'd0);
        chk("rst_busy4", 256'(busy4), 256'd0);
        chk("rst_c4", c4, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // identity: A = I, B = 1..9 -> C = 1..9
        pa = '0; pb = '0; ev = '0;
        for (int i = 0; i < 3; i++) pa[(i*3 + i)*8 +: 8] = 8'd1;
        for (int i = 0; i < 9; i++) begin
            pb[i*8 +: 8]  = 8'(i + 1);
            ev[i*16 +: 16] = 16'(i + 1);
        end
        exp3_q.push_back(ev);
        drive_start(3, pa, pb);
        @(negedge clk);
        chk("ident_busy_feed", 256'(busy3), 256'd1);
        wait_done(3, "ident", 9);
        @(negedge clk);
        chk("ident_done_pulse", 256'(done3), 256'd0);
        chk("ident_c_hold", 256'(c3), last3);

        // overflow: every element 255
        pa = '0; pb = '0; ev = '0;
        pa[71:0] = '1; pb[71:0] = '1;
`ifdef SYSTOLIC_ARRAY_SAT_EN
        for (int i = 0; i < 9; i++) ev[i*16 +: 16] = 16'd65535;
`else
        for (int i = 0; i < 9; i++) ev[i*16 +: 16] = 16'd64003;
`endif
        exp3_q.push_back(ev);
        drive_start(3, pa, pb);
        wait_done(3, "ovf", 9);

        // back-to-back: second start issued in the DONE cycle
        pa = 128'({$urandom, $urandom, $urandom});
        pb = 128'({$urandom, $urandom, $urandom});
        exp3_q.push_back(ref_mul(3, pa, pb));
        drive_start(3, pa, pb);
        wait_done(3, "b2b_first", 9);
        pa = 128'({$urandom, $urandom, $urandom});
        pb = 128'({$urandom, $urandom, $urandom});
        exp3_q.push_back(ref_mul(3, pa, pb));
        drive_start(3, pa, pb);
        repeat (5) @(negedge clk);
        chk("b2b_first_held", 256'(c3), last3);
        wait_done(3, "b2b_second", 9);

        // busy: start pulses and operand changes while busy must be ignored
        @(negedge clk);
        pa = 128'({$urandom, $urandom, $urandom});
        pb = 128'({$urandom, $urandom, $urandom});
        exp3_q.push_back(ref_mul(3, pa, pb));
        d0 = done3_cnt;
        drive_start(3, pa, pb);
        a3 = ~a3; b3 = b3 ^ 72'h5a5a5a5a5a5a5a5a5a;
        @(negedge clk);
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0; a3 = 72'hffeeddccbbaa998877;
        @(negedge clk);
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        wait_done(3, "busy_ign", 9);
        repeat (12) @(negedge clk);
        chk("busy_ign_done_count", 256'(done3_cnt - d0), 256'd1);
        chk("busy_ign_idle", 256'(busy3), 256'd0);

        // mid-operation reset
        pa = 128'({$urandom, $urandom, $urandom});
        pb = 128'({$urandom, $urandom, $urandom});
        exp3_q.push_back(ref_mul(3, pa, pb));
        drive_start(3, pa, pb);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp3_q.delete();
        d0 = done3_cnt;
        chk("midrst_c", 256'(c3), 256'd0);
        chk("midrst_busy", 256'(busy3), 256'd0);
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 256'(done3_cnt - d0), 256'd0);

        // reset wins over a simultaneous start
        rst = 1'b1; start3 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start3 = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 256'(busy3), 256'd0);

        pa = 128'({$urandom, $urandom, $urandom});
        pb = 128'({$urandom, $urandom, $urandom});
        exp3_q.push_back(ref_mul(3, pa, pb));
        drive_start(3, pa, pb);
        wait_done(3, "post_rst", 9);

        // N=4: random operands and a full-scale pattern
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j < 2) begin
                pa = {$urandom, $urandom, $urandom, $urandom};
                pb = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                pa = '1;
                pb = '1;
            end
            exp4_q.push_back(ref_mul(4, pa, pb));
            drive_start(4, pa, pb);
            wait_done(4, $sformatf("n4_run%0d", j), 12);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
